// File: rtl/rr_arb2_sel_gen.sv
// Two-requester round-robin arbiter driving a 1-to-2 enabled decoder.
// Grants are held for bursts of at most HOLD_MAX cycles, then rotated.
// All outputs come straight from flops, so sel/en/last are glitch-free.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   req0   - level request from channel 0
//   req1   - level request from channel 1
//   sel    - granted channel index (decoder select)
//   en     - grant valid (decoder enable)
//   last   - final cycle of a burst that ends by reaching HOLD_MAX
module rr_arb2_sel_gen #(
    parameter int unsigned HOLD_MAX = 4,
    parameter int unsigned CNT_W    = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    output logic sel,
    output logic en,
    output logic last
);

    localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             prio, prio_n;
    logic             sel_n, en_n, last_n;

    // Round-robin pick: tie goes to tie_ch, single requester wins, none -> no grant.
    function automatic logic [1:0] pick(input logic r0, input logic r1, input logic tie_ch);
        logic [1:0] res;  // {valid, channel}
        res = 2'b00;
        if (r0 && r1) begin
            res = {1'b1, tie_ch};
        end else if (r0) begin
            res = 2'b10;
        end else if (r1) begin
            res = 2'b11;
        end
        return res;
    endfunction

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            prio  <= 1'b0;
            sel   <= 1'b0;
            en    <= 1'b0;
            last  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            prio  <= prio_n;
            sel   <= sel_n;
            en    <= en_n;
            last  <= last_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        logic [1:0] win;
        logic       owner_req;
        logic       burst_end;

        state_n   = state;
        cnt_n     = cnt;
        prio_n    = prio;
        sel_n     = sel;
        en_n      = en;
        win       = 2'b00;
        owner_req = 1'b0;
        burst_end = 1'b0;

        unique case (state)
            IDLE: begin
                win = pick(req0, req1, prio);
                if (win[1]) begin
                    state_n = GRANT;
                    sel_n   = win[0];
                    en_n    = 1'b1;
                    cnt_n   = CNT_ONE;
                end else begin
                    en_n    = 1'b0;
                end
            end
            GRANT: begin
                owner_req = sel ? req1 : req0;
                burst_end = !owner_req || (cnt == HOLD_LIM);
                if (!burst_end) begin
                    en_n  = 1'b1;
                    cnt_n = cnt + CNT_ONE;
                end else begin
                    // Rotate priority away from the finishing owner, then re-arbitrate
                    // on the same edge so back-to-back bursts have no bubble.
                    prio_n = ~sel;
                    win    = pick(req0, req1, ~sel);
                    if (win[1]) begin
                        sel_n = win[0];
                        en_n  = 1'b1;
                        cnt_n = CNT_ONE;
                    end else begin
                        state_n = IDLE;
                        en_n    = 1'b0;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                en_n    = 1'b0;
                cnt_n   = '0;
            end
        endcase

        // Registered copy of en && (cnt == HOLD_MAX), computed from next values.
        last_n = en_n && (cnt_n == HOLD_LIM);
    end

endmodule

// File: doc/rr_arb2_sel_gen.md
Name: rr_arb2_sel_gen

Overview:
- Two-requester round-robin arbiter that sits directly upstream of the 1-to-2 enabled decoder.
- Drives that decoder's sel and en inputs, so the decoder's two outputs become one-hot grant lines.
- Grants are held for a bounded burst of at most HOLD_MAX cycles, then rotated.
- All outputs are registered, so the decoder sees glitch-free select and enable.

Parameters:
- HOLD_MAX, 4, maximum consecutive cycles one channel may hold the grant (legal range 1..2**CNT_W-1).
- CNT_W, 3, width of the burst counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req0  input  1  request from channel 0; level, held while the channel wants service.
- req1  input  1  request from channel 1; same rules as req0.
- sel  output  1  granted channel index; feeds the decoder select.
- en  output  1  grant valid; feeds the decoder enable.
- last  output  1  high during the final cycle of a burst that ends by hitting HOLD_MAX.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: sel=0, en=0, last=0, cnt=0, prio=0 (channel 0 favoured first), state=IDLE.
  - Assertion clears en immediately, without waiting for a clock edge.
  - First arbitration happens at the first rising edge after deassertion.
- Internal state:
  - State register IDLE/GRANT.
  - cnt (CNT_W bits) counts granted cycles of the current burst, including the current cycle.
  - prio (1 bit) names the channel that wins a tie.
- Arbitration function, pick(req0, req1, prio):
  - Both requesting -> prio.
  - One requesting -> that one.
  - None -> no grant.
- IDLE, evaluated at each edge:
  - Any request -> GRANT, sel<=pick, en<=1, cnt<=1.
  - Otherwise stay in IDLE, en=0, sel holds its last value.
- Latency: a request first sampled high at edge E gives en=1 from E until the next edge.
- GRANT end condition, evaluated at each edge:
  - The owner's request req[sel] is low, or
  - cnt == HOLD_MAX.
- GRANT with no end condition: sel holds, en=1, cnt<=cnt+1.
- GRANT with the end condition, same edge:
  - prio <= ~sel.
  - Re-arbitrate with pick using the updated prio and the current requests.
  - Winner exists -> stay in GRANT, sel<=winner, cnt<=1, en stays 1. No idle bubble, including when the same channel is regranted because the other is not requesting.
  - No winner -> IDLE, en<=0.
- last = en && (cnt == HOLD_MAX). It is decoded from registers only, with no combinational path from req. It is not asserted for a burst ended early by request drop.
- The counter never exceeds HOLD_MAX and never wraps.
- HOLD_MAX=1: every burst is one cycle, so under both requests sel toggles every cycle and last is constantly 1 while en=1.
- Simultaneous events:
  - Owner drops and the other channel raises at the same edge -> handoff to the other channel with no gap.
  - Both requests drop at the same edge -> IDLE.
- Requests toggling while not owner have no effect until the next arbitration edge.
- sel changes only at arbitration edges. en and sel never change mid-cycle except by reset.
- Requesters are not required to hold req until granted, but must keep req high to keep the grant.

Test Plan:
- Reset mid-burst: both req high, rst_n low during 3rd granted cycle -> en=0 and sel=0 immediately. After release with only req1 high -> first grant sel=1, en=1 one edge later.
- req0 held 10 cycles, req1 low, HOLD_MAX=4:
  - en high continuously, sel=0 throughout.
  - last pulses on granted cycles 4 and 8.
  - The burst restarts with no bubble.
- Both req held from reset:
  - sel sequence 0,0,0,0,1,1,1,1,0,... with en constantly 1.
  - last high on every 4th cycle.
- req0 high for exactly 2 sampled edges, req1 low -> en high for exactly 2 cycles, sel=0, last never asserts, then IDLE with en=0.
- Owner req0 drops at burst cycle 2 while req1 is high -> next cycle sel=1, en stays 1, cnt restarts at 1.
- HOLD_MAX=1 with both req high -> sel toggles 0,1,0,1 every cycle, en=1, last=1 continuously.
